// File: rtl/ms_pkg.sv
// Shared constants and elaboration helpers for the millisecond timebase.
package ms_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) return 0;
        return clk_hz / tick_hz;
    endfunction

    function automatic bit div_ok(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) return 1'b0;
        return (clk_hz % tick_hz == 0) && (clk_hz >= tick_hz);
    endfunction

    // Minimum 1 bit so single-entry ranges still get a legal vector.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_chan.sv
// One alarm channel: down-counts ticks and pulses alarm when it reaches terminal count.
module ms_chan
    import ms_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_evt,
    input  logic             load,
    input  logic             stop,
    input  logic [WIDTH-1:0] period,
    input  logic             periodic,
    output logic             alarm,
    output logic             busy
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             alarm_q, alarm_d;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        alarm_d  = 1'b0;
        // A config write on the tick edge replaces the old count outright.
        if (load) begin
            count_d  = period;
            reload_d = period;
            mode_d   = periodic;
            busy_d   = (period != '0);
        end else if (stop) begin
            busy_d = 1'b0;
        end else if (tick_evt && busy_q) begin
            if (count_q == WIDTH'(1)) begin
                alarm_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    count_d = reload_q;
                end else begin
                    busy_d = 1'b0;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            busy_q   <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            alarm_q  <= alarm_d;
        end
    end

    assign alarm = alarm_q;
    assign busy  = busy_q;

endmodule

// File: rtl/ms_timebase.sv
// Prescaled tick counter with N_CH programmable alarm channels.
module ms_timebase
    import ms_pkg::*;
#(
    parameter int CLK_HZ  = 2500000,
    parameter int TICK_HZ = 1000,
    parameter int WIDTH   = 32,
    parameter int N_CH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      cfg_we,
    input  logic [width_of(N_CH)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic                      cfg_periodic,
    input  logic                      cfg_stop,
    output logic [WIDTH-1:0]          out,
    output logic                      tick,
    output logic                      wrap,
    output logic [N_CH-1:0]           alarm,
    output logic [N_CH-1:0]           busy
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = width_of(DIV);
    localparam int CW  = width_of(N_CH);
    localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

    if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_bad_div
        $error("ms_timebase: CLK_HZ/TICK_HZ must be an integer >= 1");
    end

    logic [PW-1:0]    psc_q, psc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             tick_evt;

    // clr wins over a coincident tick, so channels do not advance on that edge either.
    always_comb begin
        psc_d    = psc_q;
        out_d    = out_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        tick_evt = 1'b0;
        if (clr) begin
            psc_d = '0;
            out_d = '0;
        end else if (en) begin
            if (psc_q == PSC_LAST) begin
                tick_evt = 1'b1;
                psc_d    = '0;
                out_d    = out_q + WIDTH'(1);
                tick_d   = 1'b1;
                wrap_d   = (out_q == '1);
            end else begin
                psc_d = psc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q  <= '0;
            out_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;
        assign hit = cfg_we && (cfg_ch == CW'(i));

        ms_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick_evt (tick_evt),
            .load     (hit && !cfg_stop),
            .stop     (hit && cfg_stop),
            .period   (cfg_period),
            .periodic (cfg_periodic),
            .alarm    (alarm[i]),
            .busy     (busy[i])
        );
    end

    assign out  = out_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_ms_timebase.sv
// Directed bench: default-rate instance for prescaler timing, fast 4-bit instance for wrap/clr/channels.
module tb_ms_timebase;

    logic clk = 1'b0;
    always #200 clk = ~clk;

    // Instance A: default parameters (DIV = 2500)
    logic        rst_a, en_a, clr_a, we_a, periodic_a, stop_a;
    logic [1:0]  ch_a;
    logic [31:0] period_a, out_a;
    logic        tick_a, wrap_a;
    logic [3:0]  alarm_a, busy_a;

    // Instance B: DIV = 1, WIDTH = 4, N_CH = 3 (channel index 3 is out of range)
    logic        rst_b, en_b, clr_b, we_b, periodic_b, stop_b;
    logic [1:0]  ch_b;
    logic [3:0]  period_b, out_b;
    logic        tick_b, wrap_b;
    logic [2:0]  alarm_b, busy_b;

    ms_timebase dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .clr(clr_a), .cfg_we(we_a), .cfg_ch(ch_a),
        .cfg_period(period_a), .cfg_periodic(periodic_a), .cfg_stop(stop_a),
        .out(out_a), .tick(tick_a), .wrap(wrap_a), .alarm(alarm_a), .busy(busy_a)
    );

    ms_timebase #(.CLK_HZ(1000), .TICK_HZ(1000), .WIDTH(4), .N_CH(3)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .clr(clr_b), .cfg_we(we_b), .cfg_ch(ch_b),
        .cfg_period(period_b), .cfg_periodic(periodic_b), .cfg_stop(stop_b),
        .out(out_b), .tick(tick_b), .wrap(wrap_b), .alarm(alarm_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Edges until instance A pulses tick (0 if none within budget).
    task automatic find_tick(input int budget, output int edge_no);
        edge_no = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (tick_a) begin
                edge_no = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic       en, clr, we;
        logic [1:0] ch;
        logic [3:0] period;
        logic       periodic, stop;
        logic [3:0] e_out;
        logic       e_tick, e_wrap;
        logic [2:0] e_alarm, e_busy;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic clr, input logic we, input int ch,
                                input int period, input logic periodic, input logic stop,
                                input int eo, input logic et, input logic ew,
                                input int ea, input int eb);
        vec_t v;
        v.en = en; v.clr = clr; v.we = we; v.ch = 2'(ch); v.period = 4'(period);
        v.periodic = periodic; v.stop = stop; v.e_out = 4'(eo); v.e_tick = et;
        v.e_wrap = ew; v.e_alarm = 3'(ea); v.e_busy = 3'(eb);
        return v;
    endfunction

    localparam int NV = 34;
    vec_t vt[NV];

    initial begin
        int e;
        int held_bad;

        //            en clr we ch per prd stp | out tk wr alarm  busy
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b000);
        vt[1]  = mk(0, 0, 1, 0, 3, 0, 0,   0, 0, 0, 3'b000, 3'b001);
        vt[2]  = mk(0, 0, 1, 1, 2, 1, 0,   0, 0, 0, 3'b000, 3'b011);
        vt[3]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b011);
        vt[4]  = mk(1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 3'b010, 3'b011);
        vt[5]  = mk(1, 0, 0, 0, 0, 0, 0,   3, 1, 0, 3'b001, 3'b010);
        vt[6]  = mk(1, 0, 0, 0, 0, 0, 0,   4, 1, 0, 3'b010, 3'b010);
        vt[7]  = mk(1, 0, 0, 0, 0, 0, 0,   5, 1, 0, 3'b000, 3'b010);
        vt[8]  = mk(1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 3'b010, 3'b010);
        vt[9]  = mk(1, 0, 0, 0, 0, 0, 0,   7, 1, 0, 3'b000, 3'b010);
        vt[10] = mk(1, 0, 1, 1, 5, 1, 0,   8, 1, 0, 3'b000, 3'b010);
        vt[11] = mk(1, 0, 1, 0, 2, 0, 0,   9, 1, 0, 3'b000, 3'b011);
        vt[12] = mk(1, 0, 1, 0, 0, 0, 1,  10, 1, 0, 3'b000, 3'b010);
        vt[13] = mk(1, 0, 0, 0, 0, 0, 0,  11, 1, 0, 3'b000, 3'b010);
        vt[14] = mk(1, 0, 0, 0, 0, 0, 0,  12, 1, 0, 3'b000, 3'b010);
        vt[15] = mk(1, 0, 0, 0, 0, 0, 0,  13, 1, 0, 3'b010, 3'b010);
        vt[16] = mk(1, 0, 0, 0, 0, 0, 0,  14, 1, 0, 3'b000, 3'b010);
        vt[17] = mk(1, 0, 0, 0, 0, 0, 0,  15, 1, 0, 3'b000, 3'b010);
        vt[18] = mk(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b000, 3'b010);
        vt[19] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b010);
        vt[20] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b010);
        vt[21] = mk(1, 0, 1, 3, 1, 0, 0,   2, 1, 0, 3'b010, 3'b010);
        vt[22] = mk(1, 0, 0, 0, 0, 0, 0,   3, 1, 0, 3'b000, 3'b010);
        vt[23] = mk(1, 0, 0, 0, 0, 0, 0,   4, 1, 0, 3'b000, 3'b010);
        vt[24] = mk(1, 0, 0, 0, 0, 0, 0,   5, 1, 0, 3'b000, 3'b010);
        vt[25] = mk(1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 3'b000, 3'b010);
        vt[26] = mk(1, 0, 0, 0, 0, 0, 0,   7, 1, 0, 3'b010, 3'b010);
        vt[27] = mk(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b010);
        vt[28] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b010);
        vt[29] = mk(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b010);
        vt[30] = mk(1, 0, 1, 2, 0, 0, 0,   1, 1, 0, 3'b000, 3'b010);
        vt[31] = mk(1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 3'b000, 3'b010);
        vt[32] = mk(1, 0, 0, 0, 0, 0, 0,   3, 1, 0, 3'b000, 3'b010);
        vt[33] = mk(1, 0, 0, 0, 0, 0, 0,   4, 1, 0, 3'b010, 3'b010);

        rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; we_a = 1'b0; ch_a = '0;
        period_a = '0; periodic_a = 1'b0; stop_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; we_b = 1'b0; ch_b = '0;
        period_b = '0; periodic_b = 1'b0; stop_b = 1'b0;

        #1;
        chk("reset out_a", out_a, 32'd0);
        chk("reset busy_a", 32'(busy_a), 32'd0);
        chk("reset out_b", 32'(out_b), 32'd0);
        chk("reset tick_b", 32'(tick_b), 32'd0);

        // Instance B: table of single-cycle vectors
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            en_b = vt[k].en; clr_b = vt[k].clr; we_b = vt[k].we; ch_b = vt[k].ch;
            period_b = vt[k].period; periodic_b = vt[k].periodic; stop_b = vt[k].stop;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out", k), 32'(out_b), 32'(vt[k].e_out));
            chk($sformatf("v%0d tick", k), 32'(tick_b), 32'(vt[k].e_tick));
            chk($sformatf("v%0d wrap", k), 32'(wrap_b), 32'(vt[k].e_wrap));
            chk($sformatf("v%0d alarm", k), 32'(alarm_b), 32'(vt[k].e_alarm));
            chk($sformatf("v%0d busy", k), 32'(busy_b), 32'(vt[k].e_busy));
        end
        @(negedge clk);
        we_b = 1'b0; clr_b = 1'b0; stop_b = 1'b0;

        // Instance B: asynchronous reset between edges clears everything at once
        @(posedge clk);
        #100;
        rst_b = 1'b1;
        #1;
        chk("async rst out_b", 32'(out_b), 32'd0);
        chk("async rst busy_b", 32'(busy_b), 32'd0);
        chk("async rst tick_b", 32'(tick_b), 32'd0);

        // Instance A: first tick on the 2500th enabled edge, second on the 5000th
        @(negedge clk);
        rst_a = 1'b0;
        en_a  = 1'b1;
        find_tick(3000, e);
        chk("first tick edge", 32'(e), 32'd2500);
        chk("first tick out", out_a, 32'd1);
        find_tick(3000, e);
        chk("second tick edge", 32'(e), 32'd2500);
        chk("second tick out", out_a, 32'd2);

        // Pause mid-interval for 100 cycles
        repeat (1000) @(posedge clk);
        @(negedge clk);
        en_a = 1'b0;
        held_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_a !== 32'd2 || tick_a !== 1'b0) held_bad++;
        end
        chk("en low hold errors", 32'(held_bad), 32'd0);
        chk("en low out", out_a, 32'd2);
        @(negedge clk);
        en_a = 1'b1;
        find_tick(3000, e);
        chk("tick after pause edge", 32'(e), 32'd1500);
        chk("tick after pause out", out_a, 32'd3);

        // Asynchronous reset mid-operation, then restart from a fresh prescaler
        repeat (300) @(posedge clk);
        #100;
        rst_a = 1'b1;
        #1;
        chk("async rst out_a", out_a, 32'd0);
        chk("async rst tick_a", 32'(tick_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        find_tick(3000, e);
        chk("tick after rst edge", 32'(e), 32'd2500);
        chk("tick after rst out", out_a, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
